// File: rtl/tlul_sram_mem.sv
// tlul_pkg: minimal TL-UL channel types shared by this device and its bench.
// tlul_sram_mem: TL-UL device in front of a single-port, 1-cycle-latency SRAM macro.
//   Checks every A request for protocol errors, issues legal ones to the SRAM in the
//   accept cycle, and returns D beats in order from an Outstanding-deep response queue.
//   Ports:
//     clk_i, rst_i            clock, asynchronous active-high reset
//     tl_i / tl_o             TL-UL host->device (A + d_ready) / device->host (D + a_ready)
//     lock_i                  1: Put* requests return an error
//     fetch_en_i              0: Get requests return an error
//     err_clr_i, err_cnt_o    synchronous clear / saturating count of errored requests
//     sram_*                  SRAM macro interface (rdata valid the cycle after a read)

package tlul_pkg;

  localparam logic [2:0] PutFullData    = 3'd0;
  localparam logic [2:0] PutPartialData = 3'd1;
  localparam logic [2:0] Get            = 3'd4;
  localparam logic [2:0] AccessAck      = 3'd0;
  localparam logic [2:0] AccessAckData  = 3'd1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

module tlul_sram_mem
  import tlul_pkg::*;
#(
  parameter int unsigned SramAw      = 12,
  parameter int unsigned Outstanding = 2,
  parameter int unsigned ReadOnly    = 0,
  parameter int unsigned ErrCntW     = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  tl_h2d_t            tl_i,
  output tl_d2h_t            tl_o,
  input  logic               lock_i,
  input  logic               fetch_en_i,
  input  logic               err_clr_i,
  output logic [ErrCntW-1:0] err_cnt_o,
  output logic               sram_req_o,
  output logic               sram_we_o,
  output logic [SramAw-1:0]  sram_addr_o,
  output logic [31:0]        sram_wdata_o,
  output logic [31:0]        sram_wmask_o,
  input  logic [31:0]        sram_rdata_i
);

  localparam int unsigned PtrW = (Outstanding > 1) ? $clog2(Outstanding) : 1;
  localparam int unsigned CntW = $clog2(Outstanding + 1);

  // Response queue storage
  logic [2:0]  r_op   [Outstanding];
  logic [7:0]  r_src  [Outstanding];
  logic [1:0]  r_size [Outstanding];
  logic        r_err  [Outstanding];
  logic [31:0] r_data [Outstanding];

  logic [PtrW-1:0]    r_wptr, r_rptr, r_rd_ptr;
  logic [CntW-1:0]    r_cnt;
  logic               r_rd_pend;
  logic [ErrCntW-1:0] r_err_cnt;

  logic       w_a_ready, w_acc, w_pop, w_d_valid;
  logic       w_is_get, w_is_put, w_misalign, w_err, w_legal;
  logic [3:0] w_lanes;
  logic [31:0] w_head_data;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Outstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  // a_ready depends only on registered occupancy (and reset), never on d_ready.
  assign w_a_ready = !rst_i && (r_cnt < CntW'(Outstanding));
  assign w_acc     = tl_i.a_valid && w_a_ready;
  assign w_d_valid = (r_cnt != '0);
  assign w_pop     = w_d_valid && tl_i.d_ready;

  assign w_is_get = (tl_i.a_opcode == Get);
  assign w_is_put = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);

  // Byte lanes covered by the sized, aligned access.
  always_comb begin
    w_lanes    = 4'b0000;
    w_misalign = 1'b0;
    case (tl_i.a_size)
      2'd0: w_lanes = 4'b0001 << tl_i.a_address[1:0];
      2'd1: begin
        w_lanes    = 4'b0011 << {tl_i.a_address[1], 1'b0};
        w_misalign = tl_i.a_address[0];
      end
      2'd2: begin
        w_lanes    = 4'b1111;
        w_misalign = |tl_i.a_address[1:0];
      end
      default: w_lanes = 4'b0000;
    endcase
  end

  always_comb begin
    w_err = 1'b0;
    if (!(w_is_get || w_is_put))                                   w_err = 1'b1;
    if (tl_i.a_size > 2'd2)                                         w_err = 1'b1;
    if (w_misalign)                                                 w_err = 1'b1;
    if (|(tl_i.a_mask & ~w_lanes))                                  w_err = 1'b1;
    if ((tl_i.a_opcode == PutFullData) && (tl_i.a_mask != w_lanes)) w_err = 1'b1;
    if (w_is_put && ((ReadOnly != 0) || lock_i))                    w_err = 1'b1;
    if (w_is_get && !fetch_en_i)                                    w_err = 1'b1;
  end

  assign w_legal = w_acc && !w_err;

  assign sram_req_o   = w_legal;
  assign sram_we_o    = w_legal && w_is_put;
  assign sram_addr_o  = tl_i.a_address[SramAw+1:2];
  assign sram_wdata_o = tl_i.a_data;
  assign sram_wmask_o = {{8{tl_i.a_mask[3]}}, {8{tl_i.a_mask[2]}},
                         {8{tl_i.a_mask[1]}}, {8{tl_i.a_mask[0]}}};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_cnt     <= '0;
      r_rd_pend <= 1'b0;
      r_rd_ptr  <= '0;
      for (int i = 0; i < int'(Outstanding); i++) begin
        r_op[i]   <= '0;
        r_src[i]  <= '0;
        r_size[i] <= '0;
        r_err[i]  <= 1'b0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_acc) begin
        r_op[r_wptr]   <= w_is_get ? AccessAckData : AccessAck;
        r_src[r_wptr]  <= tl_i.a_source;
        r_size[r_wptr] <= tl_i.a_size;
        r_err[r_wptr]  <= w_err;
        r_data[r_wptr] <= '0;
        r_wptr         <= ptr_inc(r_wptr);
      end
      // Read data arrives one cycle after the request; park it in its entry.
      if (r_rd_pend) r_data[r_rd_ptr] <= sram_rdata_i;
      r_rd_pend <= w_legal && w_is_get;
      r_rd_ptr  <= r_wptr;
      if (w_pop) r_rptr <= ptr_inc(r_rptr);
      case ({w_acc, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err_cnt <= '0;
    end else if (err_clr_i) begin
      r_err_cnt <= '0;
    end else if (w_acc && w_err && (r_err_cnt != {ErrCntW{1'b1}})) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign err_cnt_o = r_err_cnt;

  // A read at the head in its first response cycle takes data straight from the SRAM.
  assign w_head_data = (r_rd_pend && (r_rd_ptr == r_rptr)) ? sram_rdata_i : r_data[r_rptr];

  always_comb begin
    tl_o         = '0;
    tl_o.a_ready = w_a_ready;
    tl_o.d_valid = w_d_valid;
    if (w_d_valid) begin
      tl_o.d_opcode = r_op[r_rptr];
      tl_o.d_size   = r_size[r_rptr];
      tl_o.d_source = r_src[r_rptr];
      tl_o.d_error  = r_err[r_rptr];
      tl_o.d_data   = w_head_data;
    end
  end

  logic w_unused;
  assign w_unused = ^{tl_i.a_param, tl_i.a_address};

endmodule

// File: doc/tlul_sram_mem.md
Name: tlul_sram_mem

Overview:
- Parametrised TL-UL device wrapping one single-port, 1-cycle-latency SRAM macro. Generation-2 instruction/data memory slave.
- Integrates the TL-UL A/D handling and an Outstanding-deep response queue; no separate adapter is used.
- Adds a read-only mode, a runtime write lock, a fetch gate, full protocol error checking and a saturating error counter.
- Sits between a crossbar device port and the SRAM macro.

Parameters:
- SramAw, 12, SRAM word-address width; depth = 2**SramAw 32-bit words.
- Outstanding, 2, response-queue depth (1..8); maximum accepted-but-unanswered requests.
- ReadOnly, 0, 1: every Put* returns an error and never reaches the SRAM.
- ErrCntW, 8, width of the error counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- tl_i  in  tlul_pkg::tl_h2d_t  TL-UL A channel plus d_ready
- tl_o  out  tlul_pkg::tl_d2h_t  TL-UL D channel plus a_ready
- lock_i  in  1  1: writes return an error
- fetch_en_i  in  1  0: Get returns an error
- err_clr_i  in  1  synchronous clear of err_cnt_o
- err_cnt_o  out  ErrCntW  saturating count of errored requests
- sram_req_o  out  1  SRAM enable
- sram_we_o  out  1  SRAM write enable
- sram_addr_o  out  SramAw  word address = a_address[SramAw+1:2]
- sram_wdata_o  out  32  write data
- sram_wmask_o  out  32  bit mask; each a_mask bit expanded to 8 bits
- sram_rdata_i  in  32  valid the cycle after a read req

Behaviour:
- Reset values: queue empty; a_ready=0 while rst_i=1; d_valid=0; d_* fields 0; err_cnt_o=0. sram_req_o/sram_we_o are forced 0 during reset.
- Reset may assert mid-operation. All in-flight requests are dropped and no D beat is issued for them.
- Queue occupancy count covers entries awaiting data as well as entries awaiting d_ready.
- a_ready = (count < Outstanding). It is registered-state only: no combinational d_ready->a_ready path.
- A request is accepted when a_valid & a_ready. Legal opcodes: Get=4, PutFullData=0, PutPartialData=1.
- Error if any of the following holds:
  - illegal opcode;
  - a_size>2;
  - address not aligned to a_size;
  - a_mask has bits outside the sized/aligned lanes;
  - PutFullData mask is not exactly the sized lanes;
  - Put* while ReadOnly=1 or lock_i=1;
  - Get while fetch_en_i=0.
- Legal request: sram_req_o=1 in the accept cycle.
  - Write: sram_we_o=1, with wmask/wdata as above.
  - Read: sram_we_o=0. rdata is captured into the queue entry on the next cycle.
- Errored request: no SRAM access. The entry records d_error=1, d_data=0 and increments err_cnt_o (saturating at all-ones).
- err_clr_i has priority over the increment in the same cycle.
- Queue entry contents: d_opcode (AccessAckData=1 for Get, AccessAck=0 otherwise), d_source, d_size and d_error copied from the request.
- D channel timing:
  - d_valid is asserted for the head entry from cycle N+1 at the earliest, where N is the accept cycle. This applies to all request types.
  - Responses are strictly in acceptance order.
  - d_data is 0 for non-Get responses.
- While d_valid & !d_ready, all d_* fields hold stable. A pop occurs on d_valid & d_ready.
- A push and a pop in the same cycle leave count unchanged. Read/write pointers wrap modulo Outstanding.
- With Outstanding>=2 and d_ready held high, back-to-back accepts sustain 1 request per cycle.
- Write-then-read to the same word in consecutive cycles returns the new data; the SRAM is a 1-cycle single port, so no hazard logic is needed.

Test Plan:
- Reset, then PutFullData addr 0x10 data 0xDEADBEEF, then Get 0x10 -> AccessAck with d_error=0, then AccessAckData with d_data=0xDEADBEEF, d_valid exactly 1 cycle after each accept.
- PutPartialData addr 0x10 mask 4'b0010 data 0x0000_5500, then Get -> 0xDEAD55EF.
- Outstanding=2, d_ready=0, three Gets offered -> a_ready drops after 2 accepts. Raising d_ready returns both in order with source IDs preserved, then the third is accepted.
- Each error case below -> d_error=1, sram_req_o never asserted, err_cnt_o increments 1..4:
  - lock_i=1 with PutFullData;
  - fetch_en_i=0 with Get;
  - opcode 3;
  - a_size=2 with addr 0x2.
- Drive 260 errors -> err_cnt_o saturates at 255. Then err_clr_i concurrent with an error -> 0.
- Two Gets accepted, assert rst_i mid-response -> d_valid=0 immediately. After release, no stale beat; count=0 and a_ready=1.
